piso_tx: RTL and testbench

PISO_TX -- requirements
Module: piso_tx

---
 rtl/piso_tx.sv | 68 ++++++
 tb/tb_piso_tx.sv | 120 ++++++++++++
 2 files changed

// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter, LSB first, with a one-word holding register
// so back-to-back words stream without idle cycles.
module piso_tx #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enb,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_en,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] hold, hold_n, shreg, shreg_n;
    logic hold_full, hold_full_n, last, load;
    logic [CW-1:0] cnt, cnt_n;
    assign in_ready = enb & ~hold_full;
    assign last     = cnt == CW'(WIDTH - 1);
    // a held word moves into the shifter when idle or on the final bit of the current word
    assign load     = enb & hold_full & ((state == IDLE) | last);
    assign ser_out  = shreg[0];
    assign ser_en   = (state == SHIFT) & enb;
    assign busy     = (state == SHIFT) | hold_full;
    always_comb begin
        state_n     = state;
        hold_n      = hold;
        hold_full_n = hold_full;
        shreg_n     = shreg;
        cnt_n       = cnt;
        if (enb) begin
            if (state == SHIFT && !last) begin
                shreg_n = shreg >> 1;
                cnt_n   = cnt + 1'b1;
            end
            if (state == SHIFT && last) state_n = IDLE;
            if (load) begin
                shreg_n     = hold;
                cnt_n       = '0;
                hold_full_n = 1'b0;
                state_n     = SHIFT;
            end
            if (in_valid & in_ready) begin
                hold_n      = in_data;
                hold_full_n = 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            hold      <= '0;
            hold_full <= 1'b0;
            shreg     <= '0;
            cnt       <= '0;
        end else begin
            state     <= state_n;
            hold      <= hold_n;
            hold_full <= hold_full_n;
            shreg     <= shreg_n;
            cnt       <= cnt_n;
        end
    end
endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: scoreboard bench; a word-level model predicts handshake/strobe timing and the bit stream.
module tb_piso_tx;
    localparam int W = 4;
    logic clk = 0, rst = 1, enb = 1, in_valid = 0;
    logic [W-1:0] in_data = '0;
    logic in_ready, ser_out, ser_en, busy;
    int total = 0, bad = 0;
    int m_bl = 0, nb = 0;
    logic m_hf = 0, frozen = 0, armed = 0, last_so = 0;
    logic [W-1:0] sipo = '0;
    bit sb[$];
    logic [W-1:0] wq[$];

    piso_tx #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .enb(enb), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .ser_out(ser_out), .ser_en(ser_en), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    // Drive one cycle of inputs, then advance the model across the rising edge.
    task automatic step(input logic r, input logic e, input logic v, input logic [W-1:0] d);
        logic acc;
        rst = r; enb = e; in_valid = v; in_data = d;
        @(posedge clk);
        frozen = !r && !e;
        if (r) begin
            m_bl = 0; m_hf = 0; nb = 0;
            sb.delete(); wq.delete();
        end else if (e) begin
            acc = v && !m_hf;
            if (m_bl > 0) m_bl--;
            if (m_hf && m_bl == 0) begin
                m_bl = W; m_hf = 0;
            end
            if (acc) begin
                m_hf = 1;
                for (int i = 0; i < W; i++) sb.push_back(d[i]);
                wq.push_back(d);
            end
        end
        armed = 1;
        #2;
    endtask

    always @(negedge clk) begin
        if (armed) begin
            chk("in_ready", in_ready, enb & !m_hf);
            chk("busy", busy, (m_bl > 0) || m_hf);
            chk("ser_en", ser_en, enb && (m_bl > 0));
            if (frozen) chk("ser_out_hold", ser_out, last_so);
            if (ser_en) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL ser_en_extra: got strobe expected none at %0t", $time);
                end else begin
                    chk("ser_out", ser_out, sb.pop_front());
                    sipo = {ser_out, sipo[W-1:1]};
                    nb++;
                    if (nb == W) begin
                        chk("sipo_word", sipo, wq.pop_front());
                        nb = 0;
                    end
                end
            end
        end
        last_so = ser_out;
    end

    initial begin
        step(1, 1, 1, 4'hF);
        step(1, 1, 1, 4'hF);
        chk("rst_ser_out", ser_out, 0);
        chk("rst_busy", busy, 0);
        step(0, 1, 0, 4'h0);
        // single word, then idle
        step(0, 1, 1, 4'b1011);
        repeat (6) step(0, 1, 0, 4'h0);
        chk("single_idle_busy", busy, 0);
        // back-to-back A then 5
        step(0, 1, 1, 4'hA);
        repeat (2) step(0, 1, 1, 4'h5);
        repeat (9) step(0, 1, 0, 4'h0);
        // freeze mid-word
        step(0, 1, 1, 4'hC);
        repeat (2) step(0, 1, 0, 4'h0);
        repeat (3) step(0, 0, 1, 4'h3);
        repeat (4) step(0, 1, 0, 4'h0);
        // reset mid-word with a word held
        step(0, 1, 1, 4'h9);
        repeat (2) step(0, 1, 1, 4'h6);
        step(1, 1, 0, 4'h0);
        chk("midrst_busy", busy, 0);
        chk("midrst_in_ready", in_ready, 1);
        repeat (6) step(0, 1, 0, 4'h0);
        // data offered while holding must be ignored
        step(0, 1, 1, 4'h2);
        step(0, 1, 1, 4'h7);
        step(0, 1, 1, 4'hF);
        repeat (10) step(0, 1, 0, 4'h0);
        // randomized traffic
        for (int i = 0; i < 800; i++)
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 9) < 8),
                 ($urandom_range(0, 9) < 6), W'($urandom));
        for (int i = 0; i < 200; i++) step(0, 1, 1, W'($urandom));
        for (int i = 0; i < 100 && (m_bl > 0 || m_hf); i++) step(0, 1, 0, 4'h0);
        chk("drain_bits", sb.size(), 0);
        chk("drain_words", wq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
